// File: rtl/reg_file_pkg.sv
// Shared definitions for the CPU register file: default widths and the
// register-address type used by decode and control logic.
package reg_file_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_NUM_REGS   = 2 ** RF_ADDR_WIDTH;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_read_mux.sv
// One asynchronous read port: selects a single register out of the flop array.
module reg_read_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGS],
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    assign data_o = regs_i[addr_i];

endmodule : reg_read_mux

// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file: two combinational read ports and one
// synchronous write port. Register 0 is an ordinary register; no bypass path.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

    // NOTE: copying mem_q into mem_d first gives every element a value on every
    // path, so no latches are inferred when reg_write is low.
    always_comb begin
        mem_d = mem_q;
        if (reg_write) begin
            mem_d[write_reg] = write_data;
        end
    end

    // NOTE: this array is built from flops, not a RAM macro, so an asynchronous
    // clear of every entry is legal and gives a defined state after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    reg_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_read_mux1 (
        .regs_i (mem_q),
        .addr_i (read_reg1),
        .data_o (read_data1)
    );

    reg_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_read_mux2 (
        .regs_i (mem_q),
        .addr_i (read_reg2),
        .data_o (read_data2)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic,
// compared against a plain array model of the 32 registers.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clock;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    logic [31:0] ref_mem [32];
    int          n_vec;
    int          n_err;

    reg_file dut (
        .clock      (clock),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present two read addresses and compare both ports against the model.
    task automatic read_pair(input int a1, input int a2, input string tag);
        read_reg1 = 5'(a1);
        read_reg2 = 5'(a2);
        #1;
        check($sformatf("%s rd1[%0d]", tag, a1), read_data1, ref_mem[a1]);
        check($sformatf("%s rd2[%0d]", tag, a2), read_data2, ref_mem[a2]);
    endtask

    // One clock of write traffic; called and returns at posedge + 1.
    task automatic step(input bit we, input int wa, input logic [31:0] wd);
        reg_write  = we;
        write_reg  = 5'(wa);
        write_data = wd;
        @(posedge clock);
        #1;
        if (we && reset) ref_mem[wa] = wd;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // Reset pulse with no clock edge.
        #1 reset = 1'b0;
        clear_model();
        read_pair(0, 17, "rst_low");
        reset = 1'b1;
        #1;
        read_pair(17, 31, "rst_rel");
        read_pair(31, 0, "rst_rel");

        @(posedge clock);
        #1;

        // Write i to register i, then read back in pairs.
        for (int i = 0; i < 32; i++) step(1'b1, i, 32'(i));
        reg_write = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            read_pair(i, i + 1, "walk");
            check("walk_lit1", read_data1, 32'(i));
            check("walk_lit2", read_data2, 32'(i + 1));
        end

        // Write enable low must block writes.
        step(1'b1, 5, 32'hA5A5_A5A5);
        for (int i = 0; i < 3; i++) step(1'b0, 5, 32'hFFFF_FFFF);
        read_pair(5, 5, "we_off");
        check("we_off_lit", read_data1, 32'hA5A5_A5A5);

        // Same-address dual read and read-during-write on register 7.
        step(1'b1, 7, 32'd3);
        reg_write = 1'b0;
        read_pair(7, 7, "dual7");
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h1234;
        #1;
        check("rdw_before1", read_data1, 32'd3);
        check("rdw_before2", read_data2, 32'd3);
        @(posedge clock);
        #1;
        ref_mem[7] = 32'h1234;
        check("rdw_after1", read_data1, 32'h1234);
        check("rdw_after2", read_data2, 32'h1234);
        reg_write = 1'b0;

        // Random traffic, including reads before each edge.
        for (int n = 0; n < 300; n++) begin
            bit          we;
            int          wa;
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            wa = int'($urandom_range(0, 31));
            wd = $urandom();
            reg_write  = we;
            write_reg  = 5'(wa);
            write_data = wd;
            read_pair(int'($urandom_range(0, 31)), wa, "rnd_pre");
            @(posedge clock);
            #1;
            if (we) ref_mem[wa] = wd;
            read_pair(wa, int'($urandom_range(0, 31)), "rnd_post");
        end

        // Reset asserted mid-cycle while a write is pending.
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'hDEAD;
        #2 reset = 1'b0;
        clear_model();
        #1;
        for (int i = 0; i < 32; i++) read_pair(i, 31 - i, "rst_mid");
        @(posedge clock);
        #1;
        read_pair(9, 0, "rst_edge");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        ref_mem[9] = 32'hDEAD;
        read_pair(9, 8, "rst_resume");
        check("rst_resume_lit", read_data1, 32'hDEAD);
        reg_write = 1'b0;

        // Isolation: load every register, then hammer register 31.
        for (int i = 0; i < 32; i++) step(1'b1, i, $urandom());
        step(1'b1, 31, 32'hFFFF_FFFF);
        reg_write = 1'b0;
        for (int i = 0; i < 32; i += 2) read_pair(i, i + 1, "iso");
        check("iso_r31", read_data2, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_file
